// File: rtl/myo_spi_pkg.sv
// Shared types and constants for the motor-board SPI frame master.
package myo_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    HOLD
  } spi_state_e;

  localparam int WORD_BITS_DEF = 16;
  localparam int NUM_WORDS_DEF = 12;
  localparam int IDX_W         = 4;

endpackage

// File: rtl/myo_spi_master_if.sv
// Caller-side bus of the SPI frame master: frame request, tx register-file
// lookup, received-word strobe and frame status.
interface myo_spi_master_if #(
  parameter int WORD_BITS = myo_spi_pkg::WORD_BITS_DEF
);
  import myo_spi_pkg::*;

  logic                 start;
  logic [WORD_BITS-1:0] tx_data;
  logic [IDX_W-1:0]     tx_word_idx;
  logic [WORD_BITS-1:0] rx_data;
  logic [IDX_W-1:0]     rx_word_idx;
  logic                 rx_valid;
  logic                 busy;
  logic                 spi_done;

  modport master (
    input  start, tx_data,
    output tx_word_idx, rx_data, rx_word_idx, rx_valid, busy, spi_done
  );

  modport slave (
    output start, tx_data,
    input  tx_word_idx, rx_data, rx_word_idx, rx_valid, busy, spi_done
  );

endinterface

// File: rtl/myo_spi_master_clk_gen.sv
// SCLK generator: CLK_DIV-cycle half period, idle low, with strobes that flag
// the clock edge on which sclk will rise or fall.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clock) begin
    if (!reset_n || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/myo_spi_master.sv
// SPI mode-1 frame master: one start shifts NUM_WORDS words out and back in.
// Define MYO_SPI_INTERWORD_GAP_EN to insert GAP_CYCLES idle cycles between words.
module myo_spi_master
  import myo_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int WORD_BITS  = WORD_BITS_DEF,
  parameter int NUM_WORDS  = NUM_WORDS_DEF,
  parameter int SS_SETUP   = 4,
  parameter int SS_HOLD    = 2,
  parameter int GAP_CYCLES = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  myo_spi_master_if.master  bus,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              ss_n
);

  localparam int CNT_MAX_A = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int BIT_W     = $clog2(WORD_BITS);

  spi_state_e           state;
  logic [CNT_W-1:0]     cyc_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     word_cnt;
  logic [WORD_BITS-1:0] tx_sr;
  logic [WORD_BITS-2:0] rx_sr;
  logic                 clk_en, sclk_rise, sclk_fall;
  logic                 setup_done, word_end, last_word, load_word;

  assign clk_en     = (state == SHIFT);
  assign setup_done = (state == SETUP) && (cyc_cnt == CNT_W'(SS_SETUP - 1));
  assign word_end   = sclk_fall && (bit_cnt == BIT_W'(WORD_BITS - 1));
  assign last_word  = (word_cnt == IDX_W'(NUM_WORDS - 1));
  assign load_word  = setup_done || (word_end && !last_word);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (clk_en),
    .sclk    (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // Shift registers carry no reset; they are reloaded before every word.
  always_ff @(posedge clock) begin
    if (load_word)
      tx_sr <= bus.tx_data;
    else if (sclk_rise)
      tx_sr <= {tx_sr[WORD_BITS-2:0], 1'b0};
    if (sclk_fall)
      rx_sr <= {rx_sr[WORD_BITS-3:0], miso};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      cyc_cnt         <= '0;
      bit_cnt         <= '0;
      word_cnt        <= '0;
      ss_n            <= 1'b1;
      mosi            <= 1'b0;
      bus.busy        <= 1'b0;
      bus.spi_done    <= 1'b0;
      bus.rx_valid    <= 1'b0;
      bus.rx_data     <= '0;
      bus.rx_word_idx <= '0;
      bus.tx_word_idx <= '0;
    end else begin
      bus.rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= SETUP;
            cyc_cnt      <= '0;
            bus.busy     <= 1'b1;
            bus.spi_done <= 1'b0;
          end
        end
        SETUP: begin
          if (setup_done) begin
            state           <= SHIFT;
            ss_n            <= 1'b0;
            bit_cnt         <= '0;
            word_cnt        <= '0;
            bus.tx_word_idx <= bus.tx_word_idx + IDX_W'(1);
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (sclk_rise)
            mosi <= tx_sr[WORD_BITS-1];
          if (word_end) begin
            bit_cnt         <= '0;
            bus.rx_valid    <= 1'b1;
            bus.rx_data     <= {rx_sr, miso};
            bus.rx_word_idx <= word_cnt;
            if (last_word) begin
              state   <= HOLD;
              cyc_cnt <= '0;
            end else begin
              word_cnt        <= word_cnt + IDX_W'(1);
              bus.tx_word_idx <= bus.tx_word_idx + IDX_W'(1);
`ifdef MYO_SPI_INTERWORD_GAP_EN
              state   <= GAP;
              cyc_cnt <= '0;
`endif
            end
          end else if (sclk_fall) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
`ifdef MYO_SPI_INTERWORD_GAP_EN
        // ss_n stays low and the clock generator idles low while disabled.
        GAP: begin
          if (cyc_cnt == CNT_W'(GAP_CYCLES - 1))
            state <= SHIFT;
          else
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
`endif
        HOLD: begin
          if (cyc_cnt == CNT_W'(SS_HOLD - 1)) begin
            state           <= IDLE;
            ss_n            <= 1'b1;
            bus.busy        <= 1'b0;
            bus.spi_done    <= 1'b1;
            bus.tx_word_idx <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myo_spi_master.sv
// Scoreboard bench for myo_spi_master with a mode-1 SPI slave model.
module tb_myo_spi_master;

`ifdef MYO_SPI_INTERWORD_GAP_EN
  localparam int FLEN    = 143;
  localparam int LOW_RUN = 10;
`else
  localparam int FLEN    = 135;
  localparam int LOW_RUN = 2;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic miso    = 1'b0;
  logic sclk, mosi, ss_n;

  always #5 clock = ~clock;

  myo_spi_master_if #(.WORD_BITS(16)) bus();

  logic [15:0] cur_tx   [2];
  logic [15:0] cur_miso [2];

  assign bus.tx_data = (bus.tx_word_idx == 4'd0) ? cur_tx[0] : cur_tx[1];

  myo_spi_master #(
    .CLK_DIV(2), .WORD_BITS(16), .NUM_WORDS(2),
    .SS_SETUP(4), .SS_HOLD(2), .GAP_CYCLES(8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .ss_n    (ss_n)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] data;
  } rx_t;

  rx_t         exp_rx   [$];
  logic [15:0] exp_mosi [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Received-word monitor.
  always @(negedge clock) begin
    rx_t e;
    if (reset_n === 1'b1 && bus.rx_valid === 1'b1) begin
      if (exp_rx.size() == 0) begin
        chk("rx_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_rx.pop_front();
        chk("rx_word_idx", {28'd0, bus.rx_word_idx}, {28'd0, e.idx});
        chk("rx_data", {16'd0, bus.rx_data}, {16'd0, e.data});
      end
    end
  end

  // SPI slave: drives miso after sclk rises, captures mosi after sclk falls.
  logic        sclk_q = 1'b0;
  int          slv_bit = 0;
  int          slv_word = 0;
  logic [15:0] slv_sh = '0;
  always @(negedge clock) begin
    logic [15:0] w;
    if (sclk === 1'b1 && sclk_q === 1'b0)
      chk("ss_n_at_sclk_rise", {31'd0, ss_n}, 32'd0);
    if (reset_n !== 1'b1 || ss_n !== 1'b0) begin
      slv_bit  = 0;
      slv_word = 0;
    end else begin
      if (sclk === 1'b1 && sclk_q === 1'b0) begin
        w    = cur_miso[slv_word & 1];
        miso = w[15 - slv_bit];
      end
      if (sclk === 1'b0 && sclk_q === 1'b1) begin
        slv_sh = {slv_sh[14:0], mosi};
        slv_bit++;
        if (slv_bit == 16) begin
          if (exp_mosi.size() == 0)
            chk("mosi_unexpected", 32'd1, 32'd0);
          else
            chk("mosi_word", {16'd0, slv_sh}, {16'd0, exp_mosi.pop_front()});
          slv_bit = 0;
          slv_word++;
        end
      end
    end
    sclk_q = sclk;
  end

  task automatic run_frame(input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] m0, input logic [15:0] m1,
                           input bit pulses);
    int n, ss_fall, run, max_run;
    bit ss_rose;
    cur_tx[0] = t0;  cur_tx[1] = t1;
    cur_miso[0] = m0; cur_miso[1] = m1;
    exp_rx.push_back('{idx: 4'd0, data: m0});
    exp_rx.push_back('{idx: 4'd1, data: m1});
    exp_mosi.push_back(t0);
    exp_mosi.push_back(t1);
    @(negedge clock) bus.start = 1'b1;
    @(negedge clock) bus.start = 1'b0;
    n = 1;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("done_low_after_start", {31'd0, bus.spi_done}, 32'd0);
    ss_fall = 0; run = 0; max_run = 0; ss_rose = 1'b0;
    while (bus.spi_done !== 1'b1 && n < 4000) begin
      bus.start = pulses && (n == 40 || n == FLEN - 1);
      @(negedge clock);
      n++;
      if (ss_n === 1'b0 && ss_fall == 0) ss_fall = n;
      if (ss_fall != 0 && ss_n === 1'b1 && bus.spi_done !== 1'b1) ss_rose = 1'b1;
      if (ss_n === 1'b0 && sclk === 1'b0) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    bus.start = 1'b0;
    chk("frame_length", n, FLEN);
    chk("ss_n_fall_cycle", ss_fall, 5);
    chk("ss_n_low_whole_frame", {31'd0, ss_rose}, 32'd0);
    chk("max_sclk_low_run", max_run, LOW_RUN);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_ss_n", {31'd0, ss_n}, 32'd1);
    chk("idle_tx_word_idx", {28'd0, bus.tx_word_idx}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    cur_tx[0] = '0; cur_tx[1] = '0;
    cur_miso[0] = '0; cur_miso[1] = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ss_n", {31'd0, ss_n}, 32'd1);
    chk("rst_spi_done", {31'd0, bus.spi_done}, 32'd0);
    chk("rst_sclk_mosi", {30'd0, sclk, mosi}, 32'd0);
    chk("rst_busy_rxv", {30'd0, bus.busy, bus.rx_valid}, 32'd0);
    chk("rst_rx_data", {16'd0, bus.rx_data}, 32'd0);
    chk("rst_idx", {24'd0, bus.tx_word_idx, bus.rx_word_idx}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(negedge clock);

    run_frame(16'hA55A, 16'h0F0F, 16'h1234, 16'hBEEF, 1'b0);
    run_frame(16'h8001, 16'h7FFE, 16'h0000, 16'hFFFF, 1'b0);

    // Starts during SHIFT and on the HOLD->IDLE edge must be dropped.
    run_frame(16'h1357, 16'h2468, 16'hC3C3, 16'h3C3C, 1'b1);
    repeat (20) @(negedge clock);
    chk("ignored_start_busy", {31'd0, bus.busy}, 32'd0);
    chk("ignored_start_done", {31'd0, bus.spi_done}, 32'd1);

    // Abort in the middle of word 1.
    cur_tx[0] = 16'hFACE;  cur_tx[1] = 16'h1111;
    cur_miso[0] = 16'h5AA5; cur_miso[1] = 16'h2222;
    exp_rx.push_back('{idx: 4'd0, data: 16'h5AA5});
    exp_mosi.push_back(16'hFACE);
    @(negedge clock) bus.start = 1'b1;
    @(negedge clock) bus.start = 1'b0;
    repeat (99) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("abort_ss_n", {31'd0, ss_n}, 32'd1);
    chk("abort_sclk", {31'd0, sclk}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_spi_done", {31'd0, bus.spi_done}, 32'd0);
    chk("abort_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("abort_mosi_idx", {27'd0, mosi, bus.tx_word_idx}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (30) @(negedge clock);
    chk("abort_rx_drained", exp_rx.size(), 32'd0);
    chk("abort_still_idle", {30'd0, bus.busy, bus.spi_done}, 32'd0);
    exp_mosi.delete();

    run_frame(16'hDEAD, 16'hC0DE, 16'h6B6B, 16'h0001, 1'b0);
    repeat (5) @(negedge clock);
    chk("final_rx_queue_empty", exp_rx.size(), 32'd0);
    chk("final_mosi_queue_empty", exp_mosi.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/myo_spi_master.md
# myo_spi_master

SPI frame master for the motor-board bus: one `start` produces one complete multi-word SPI frame. It shifts out command words from a caller-side register file and returns the received status words. Its `ss_n` and `spi_done` outputs feed the slave-select demultiplexer directly. Because `spi_done` is sequenced against `ss_n`, the demultiplexer advances to the next board before slave select is asserted.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in `clock` cycles, ≥2.
- WORD_BITS, 16: bits per word.
- NUM_WORDS, 12: words per frame.
- SS_SETUP, 4: cycles from `start` to `ss_n` low, ≥2.
- SS_HOLD, 2: cycles from the last SCLK edge to `ss_n` high.
- GAP_CYCLES, 8: idle SCLK cycles between words, used only with the gap feature.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle frame request; ignored while `busy`.
- tx_data  in  WORD_BITS  word at `tx_word_idx`; must be valid 1 cycle after the index changes.
- tx_word_idx  out  4  index of the next word to load.
- rx_data  out  WORD_BITS  last received word.
- rx_word_idx  out  4  index of `rx_data`.
- rx_valid  out  1  one-cycle strobe, `rx_data` valid.
- busy  out  1  frame in progress.
- spi_done  out  1  high from frame end until next accepted `start`.
- ss_n  out  1  active-low slave select, to the demultiplexer.
- sclk  out  1  SPI clock, CPOL=0.
- mosi  out  1  serial data out, MSB first.
- miso  in  1  serial data in.

## Operation
- SPI mode 1 (CPOL=0, CPHA=1):
  - `mosi` is updated on each SCLK rising edge.
  - `miso` is sampled on each SCLK falling edge.
- FSM states:
  - IDLE → SETUP on accepted `start`.
  - SETUP (SS_SETUP cycles) → SHIFT.
  - SHIFT (WORD_BITS SCLK periods) → GAP, or SHIFT for the next word when the gap feature is compiled out, or HOLD after the last word.
  - GAP (GAP_CYCLES) → SHIFT.
  - HOLD (SS_HOLD) → IDLE.
- Accepted `start`:
  - `busy`=1 and `spi_done`=0 on the next edge.
  - `ss_n` stays 1 throughout SETUP.
- `ss_n`=0 from SETUP exit through HOLD, inclusive of GAP. It returns to 1 on entry to IDLE.
- On entry to IDLE: `spi_done`=1, `busy`=0.
- Word load and advance:
  - The shift register loads `tx_data` on SETUP exit (word 0) and at each word boundary.
  - `tx_word_idx` increments the cycle after each load.
  - `tx_word_idx` returns to 0 on entry to IDLE.
- After the last falling-edge sample of word k: `rx_valid`=1 for one cycle, `rx_word_idx`=k.
- `start` while `busy`: ignored, with no queueing.
- A `start` arriving in the same cycle as HOLD → IDLE is ignored.
- Reset values:
  - `ss_n`=1, `spi_done`=0.
  - `sclk`, `mosi`, `busy`, `rx_valid`=0.
  - `rx_data`=0, `tx_word_idx`=0, `rx_word_idx`=0.
- Reset mid-frame: all outputs return to reset values on the next `clock` edge, and the FSM goes to IDLE. No partial `rx_valid` is issued.
- `spi_done` is 0 after reset and first rises at the end of frame 0. The demultiplexer therefore addresses board 0 for the first frame and advances once per later frame.

## Timing
- Bit period: 2·CLK_DIV cycles. `sclk` rises CLK_DIV cycles after SHIFT entry.
- Frame length, from the `start` cycle to `spi_done` rising: SS_SETUP + NUM_WORDS·WORD_BITS·2·CLK_DIV + (NUM_WORDS−1)·GAP_CYCLES (gap feature only) + SS_HOLD + 1.
- `rx_valid` fires 1 cycle after the final falling edge of each word.
- The `spi_done` falling edge always precedes the `ss_n` falling edge by SS_SETUP ≥ 2 cycles. This gives the demultiplexer its registered edge-detect time.

## Configuration
- `MYO_SPI_INTERWORD_GAP_EN` defined:
  - A GAP state of GAP_CYCLES follows every word except the last.
  - During GAP, `ss_n` stays low, `sclk` is held at 0, and `mosi` holds its last bit.
- Not defined: words are shifted back-to-back, the GAP state and GAP_CYCLES are unused, and the frame-length formula drops the gap term.

## Structure
- Package `myo_spi_pkg` holds:
  - the FSM state enum (IDLE, SETUP, SHIFT, GAP, HOLD);
  - the WORD_BITS and NUM_WORDS default constants;
  - the index width constant (4).
- Sub-module `spi_clk_gen` is a CLK_DIV counter that produces the `sclk` level plus one-cycle rise and fall strobes. It is enabled only in SHIFT and resets to 0 when disabled.

## Test plan
All scenarios use CLK_DIV=2, WORD_BITS=16, NUM_WORDS=2, SS_SETUP=4, SS_HOLD=2, and gap disabled unless stated.
- Single frame, tx words {0xA55A, 0x0F0F}, `miso` driven from {0x1234, 0xBEEF}:
  - `mosi` bitstream matches MSB first.
  - `rx_valid` twice, rx_word_idx 0/1, rx_data 0x1234/0xBEEF.
  - `spi_done` rises at cycle 135 after `start`.
- Two back-to-back frames: `spi_done` falls exactly 4 cycles before `ss_n` falls. `ss_n`=1 at every rising SCLK edge outside a frame.
- `start` pulsed during SHIFT and on the HOLD→IDLE cycle → ignored, with no extra frame.
- `reset_n`=0 mid-word 1: next edge `ss_n`=1, `sclk`=0, `busy`=0, `spi_done`=0, with no `rx_valid`. A fresh `start` then runs a full frame.
- `MYO_SPI_INTERWORD_GAP_EN`, GAP_CYCLES=8:
  - `ss_n` stays low and `sclk` stays 0 for 8 cycles between words.
  - `spi_done` rises at cycle 143.
